ex_mem_skid_reg: RTL and testbench
==================================

// Module: ex_mem_skid_reg
// PURPOSE
//  Parametrised EX/MEM pipeline register with a valid/ready handshake and a 2-entry skid buffer.
//  Carries control bits, ALU result, store data and destination register from EX to MEM.
//  Adds stall back-pressure, flush (bubble insertion) and forced-zero of side-effect controls on bubbles.
//  Adds a saturating stall counter for performance monitoring.
// PARAMETERS
//  CTRL_W     4        control field width; bit3 RegWrite, bit2 MemtoReg, bit1 MemRead, bit0 MemWrite
//  DATA_W     32       ALU result / store data width
//  RD_W       5        destination register address width
//  SAFE_MASK  4'b1001  ctrl bits forced to 0 on ctrl_o whenever out_valid_o=0 (RegWrite, MemWrite)
//  CNT_W      16       stall counter width
// PORTS
//  clk_i          in   1       clock, all state updates on posedge
//  rst_i          in   1       synchronous reset, active-high
//  flush_i        in   1       synchronous flush: discard all held entries
//  in_valid_i     in   1       EX presents a valid entry
//  in_ready_o     out  1       register can accept an entry this cycle
//  ctrl_i         in   CTRL_W  control bits from EX
//  alu_i          in   DATA_W  ALU result
//  wdata_i        in   DATA_W  memory write data
//  rd_i           in   RD_W    destination register address
//  out_valid_o    out  1       entry valid towards MEM
//  out_ready_i    in   1       MEM accepts the entry this cycle
//  ctrl_o         out  CTRL_W  control bits (SAFE_MASK bits gated by out_valid_o)
//  alu_o          out  DATA_W  ALU result
//  wdata_o        out  DATA_W  memory write data
//  rd_o           out  RD_W    destination register address
//  stall_cnt_o    out  CNT_W   cycles with out_valid_o=1 and out_ready_i=0
// BEHAVIOUR
//  - Storage: main entry (drives outputs) + skid entry. in fire = in_valid_i&in_ready_o; out fire = out_valid_o&out_ready_i.
//  - FSM (registered), in_ready_o = (state!=TWO), out_valid_o = (state!=EMPTY); both are decoded from registered state only, with no combinational in->out path.
//    EMPTY: in fire -> main<=input, ONE; else stay.
//    ONE:   in fire & out fire -> main<=input, ONE; in fire & !out fire -> skid<=input, TWO;
//           !in fire & out fire -> EMPTY; else hold.
//    TWO:   no input accepted; out fire -> main<=skid, ONE; else hold.
//  - Latency: 1 cycle from in fire (EMPTY or ONE-with-drain) to out_valid_o; 2 cycles when the entry waits in skid.
//  - Order strictly preserved; no entry is dropped or duplicated except by flush/reset.
//  - While out_valid_o=1 & out_ready_i=0, all outputs are held bit-stable.
//  - ctrl_o = main_ctrl & ~(SAFE_MASK & {CTRL_W{~out_valid_o}}); non-masked bits and data hold their last value when invalid.
//  - Flush: next state EMPTY regardless of in_valid_i/out_ready_i; a same-cycle input is discarded; data regs not cleared.
//  - Priority: rst_i > flush_i > handshake.
//  - Reset: state EMPTY (out_valid_o=0, in_ready_o=1), all ctrl/data/rd regs 0, stall_cnt_o 0.
//    Reset mid-transfer discards both entries.
//  - stall_cnt_o: +1 each cycle out_valid_o=1 & out_ready_i=0; saturates at all-ones; cleared by reset only, not flush.
//  - DATA_W/RD_W/CTRL_W pass through unmodified; no arithmetic on payload.
// TESTING
//  1 Reset: assert rst_i 2 cycles with in_valid_i=1 -> out_valid_o=0, ctrl_o=0, alu_o=0, in_ready_o=1, stall_cnt_o=0.
//  2 Streaming: out_ready_i=1, entries alu=1..8 back-to-back -> appear on alu_o 1 cycle later in order, one per cycle.
//  3 Back-pressure: out_ready_i=0 while sending A,B,C -> A held on outputs, B in skid, in_ready_o=0, C stalls;
//    release -> A,B,C in order; stall_cnt_o equals stalled cycles.
//  4 Flush: state TWO, flush_i=1 with in_valid_i=1 -> next cycle out_valid_o=0, ctrl_o[3]=ctrl_o[0]=0, in_ready_o=1, input lost.
//  5 Bubble safety: ctrl_i=4'b1111 accepted then drained -> with out_valid_o=0, ctrl_o=4'b0110 (RegWrite/MemWrite forced 0).
//  6 Saturation: CNT_W=4, out_ready_i=0 for 20 cycles -> stall_cnt_o stops at 15; flush leaves it at 15.

Source files
------------

// File: rtl/ex_mem_skid_reg.sv
// EX/MEM pipeline register with a two-entry skid buffer, flush-driven bubble insertion
// and a saturating stall counter. Handshake outputs decode only from registered state.
module ex_mem_skid_reg #(
    parameter int                CTRL_W    = 4,
    parameter int                DATA_W    = 32,
    parameter int                RD_W      = 5,
    parameter logic [CTRL_W-1:0] SAFE_MASK = CTRL_W'(4'b1001),
    parameter int                CNT_W     = 16
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              flush_i,
    input  logic              in_valid_i,
    output logic              in_ready_o,
    input  logic [CTRL_W-1:0] ctrl_i,
    input  logic [DATA_W-1:0] alu_i,
    input  logic [DATA_W-1:0] wdata_i,
    input  logic [RD_W-1:0]   rd_i,
    output logic              out_valid_o,
    input  logic              out_ready_i,
    output logic [CTRL_W-1:0] ctrl_o,
    output logic [DATA_W-1:0] alu_o,
    output logic [DATA_W-1:0] wdata_o,
    output logic [RD_W-1:0]   rd_o,
    output logic [CNT_W-1:0]  stall_cnt_o
);

    localparam int PW = CTRL_W + 2 * DATA_W + RD_W;

    typedef enum logic [1:0] {
        EMPTY,
        ONE,
        TWO
    } state_t;

    state_t          state, state_next;
    logic [PW-1:0]   in_pl, main_pl, skid_pl;
    logic            in_fire, out_fire;
    logic            load_main_in, load_skid, load_main_skid;
    logic [CTRL_W-1:0] main_ctrl;
    logic [CNT_W-1:0]  stall_cnt;

    assign in_ready_o  = (state != TWO);
    assign out_valid_o = (state != EMPTY);
    assign in_fire     = in_valid_i & in_ready_o;
    assign out_fire    = out_valid_o & out_ready_i;
    assign in_pl       = {ctrl_i, alu_i, wdata_i, rd_i};

    always_comb begin
        state_next     = state;
        load_main_in   = 1'b0;
        load_skid      = 1'b0;
        load_main_skid = 1'b0;
        case (state)
            EMPTY: begin
                if (in_fire) begin
                    load_main_in = 1'b1;
                    state_next   = ONE;
                end
            end
            ONE: begin
                if (in_fire && out_fire) begin
                    load_main_in = 1'b1;
                end else if (in_fire) begin
                    load_skid  = 1'b1;
                    state_next = TWO;
                end else if (out_fire) begin
                    state_next = EMPTY;
                end
            end
            TWO: begin
                if (out_fire) begin
                    load_main_skid = 1'b1;
                    state_next     = ONE;
                end
            end
            default: state_next = EMPTY;
        endcase
    end

    // The stall counter keeps counting through a flush; only reset clears it.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state     <= EMPTY;
            main_pl   <= '0;
            skid_pl   <= '0;
            stall_cnt <= '0;
        end else begin
            if (out_valid_o && !out_ready_i && (stall_cnt != {CNT_W{1'b1}}))
                stall_cnt <= stall_cnt + CNT_W'(1);
            if (flush_i) begin
                state <= EMPTY;
            end else begin
                state <= state_next;
                if (load_main_in)
                    main_pl <= in_pl;
                else if (load_main_skid)
                    main_pl <= skid_pl;
                if (load_skid)
                    skid_pl <= in_pl;
            end
        end
    end

    assign main_ctrl   = main_pl[PW-1 -: CTRL_W];
    assign ctrl_o      = main_ctrl & ~(SAFE_MASK & {CTRL_W{~out_valid_o}});
    assign alu_o       = main_pl[2*DATA_W+RD_W-1 -: DATA_W];
    assign wdata_o     = main_pl[DATA_W+RD_W-1 -: DATA_W];
    assign rd_o        = main_pl[RD_W-1:0];
    assign stall_cnt_o = stall_cnt;

endmodule

// File: tb/tb_ex_mem_skid_reg.sv
// Self-checking bench for ex_mem_skid_reg: directed vector table, saturation sequence on a
// narrow-counter instance, and randomized traffic against a queue-based reference model.
module tb_ex_mem_skid_reg;

    localparam int CTRL_W = 4;
    localparam int DATA_W = 32;
    localparam int RD_W   = 5;
    localparam int CNT_W  = 16;

    logic              clk = 1'b0;
    logic              rst, flush, in_valid, out_ready;
    logic              in_ready, out_valid;
    logic [CTRL_W-1:0] ctrl_in, ctrl_out;
    logic [DATA_W-1:0] alu_in, alu_out, wdata_in, wdata_out;
    logic [RD_W-1:0]   rd_in, rd_out;
    logic [CNT_W-1:0]  stall_cnt;

    logic              s_rst, s_flush, s_in_valid, s_out_ready;
    logic              s_in_ready, s_out_valid;
    logic [CTRL_W-1:0] s_ctrl_out;
    logic [DATA_W-1:0] s_alu_out, s_wdata_out;
    logic [RD_W-1:0]   s_rd_out;
    logic [3:0]        s_stall_cnt;

    always #5 clk = ~clk;

    ex_mem_skid_reg #(.CTRL_W(CTRL_W), .DATA_W(DATA_W), .RD_W(RD_W), .CNT_W(CNT_W)) dut (
        .clk_i(clk), .rst_i(rst), .flush_i(flush),
        .in_valid_i(in_valid), .in_ready_o(in_ready),
        .ctrl_i(ctrl_in), .alu_i(alu_in), .wdata_i(wdata_in), .rd_i(rd_in),
        .out_valid_o(out_valid), .out_ready_i(out_ready),
        .ctrl_o(ctrl_out), .alu_o(alu_out), .wdata_o(wdata_out), .rd_o(rd_out),
        .stall_cnt_o(stall_cnt)
    );

    ex_mem_skid_reg #(.CTRL_W(CTRL_W), .DATA_W(DATA_W), .RD_W(RD_W), .CNT_W(4)) dut_sat (
        .clk_i(clk), .rst_i(s_rst), .flush_i(s_flush),
        .in_valid_i(s_in_valid), .in_ready_o(s_in_ready),
        .ctrl_i(4'b1111), .alu_i(32'd5), .wdata_i(32'd6), .rd_i(5'd7),
        .out_valid_o(s_out_valid), .out_ready_i(s_out_ready),
        .ctrl_o(s_ctrl_out), .alu_o(s_alu_out), .wdata_o(s_wdata_out), .rd_o(s_rd_out),
        .stall_cnt_o(s_stall_cnt)
    );

    typedef struct {
        logic              flush;
        logic              in_valid;
        logic              out_ready;
        logic [CTRL_W-1:0] ctrl;
        logic [DATA_W-1:0] alu;
        logic              exp_ov;
        logic              exp_ir;
        logic [CTRL_W-1:0] exp_ctrl;
        logic [DATA_W-1:0] exp_alu;
        logic [CNT_W-1:0]  exp_cnt;
    } vec_t;

    typedef struct {
        logic [CTRL_W-1:0] ctrl;
        logic [DATA_W-1:0] alu;
        logic [DATA_W-1:0] wdata;
        logic [RD_W-1:0]   rd;
    } entry_t;

    int checks   = 0;
    int failures = 0;

    function automatic vec_t mk(logic f, logic iv, logic orr, logic [3:0] c, logic [31:0] a,
                                logic eov, logic eir, logic [3:0] ec, logic [31:0] ea,
                                logic [15:0] ecnt);
        vec_t v;
        v.flush = f; v.in_valid = iv; v.out_ready = orr; v.ctrl = c; v.alu = a;
        v.exp_ov = eov; v.exp_ir = eir; v.exp_ctrl = ec; v.exp_alu = ea; v.exp_cnt = ecnt;
        return v;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(string name, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic applyStimulus(input vec_t v);
        flush     = v.flush;
        in_valid  = v.in_valid;
        out_ready = v.out_ready;
        ctrl_in   = v.ctrl;
        alu_in    = v.alu;
        wdata_in  = ~v.alu;
        rd_in     = v.alu[4:0];
    endtask

    initial begin
        vec_t   tbl[$];
        entry_t q[$];
        entry_t last;
        entry_t e;
        logic [CTRL_W-1:0] exp_c;
        int     model_cnt;
        logic   m_ov, m_ir, in_fire, out_fire;

        rst = 1'b1; flush = 1'b0; in_valid = 1'b1; out_ready = 1'b0;
        ctrl_in = 4'b1111; alu_in = 32'hDEAD; wdata_in = 32'hBEEF; rd_in = 5'd3;
        s_rst = 1'b1; s_flush = 1'b0; s_in_valid = 1'b0; s_out_ready = 1'b0;

        // Reset held two cycles with a valid input present.
        tick();
        tick();
        checkOutput("reset_out_valid", 64'(out_valid), 64'd0);
        checkOutput("reset_in_ready",  64'(in_ready),  64'd1);
        checkOutput("reset_ctrl",      64'(ctrl_out),  64'd0);
        checkOutput("reset_alu",       64'(alu_out),   64'd0);
        checkOutput("reset_cnt",       64'(stall_cnt), 64'd0);
        rst = 1'b0;

        // Streaming: one per cycle, one-cycle latency; last entry carries all ctrl bits.
        for (int i = 1; i <= 8; i++)
            tbl.push_back(mk(0, 1, 1, (i == 8) ? 4'b1111 : 4'b0110, 32'(i),
                             i > 1, 1, (i == 1) ? 4'b0000 : 4'b0110, 32'(i - 1), 0));
        tbl.push_back(mk(0, 0, 1, 4'b0, 32'd0, 1, 1, 4'b1111, 32'd8, 0));
        tbl.push_back(mk(0, 0, 1, 4'b0, 32'd0, 0, 1, 4'b0110, 32'd8, 0));
        // Back-pressure: A held, B in skid, C stalls, then drains in order.
        tbl.push_back(mk(0, 1, 0, 4'b1001, 32'hA, 0, 1, 4'b0110, 32'd8, 0));
        tbl.push_back(mk(0, 1, 0, 4'b0010, 32'hB, 1, 1, 4'b1001, 32'hA, 0));
        tbl.push_back(mk(0, 1, 0, 4'b0100, 32'hC, 1, 0, 4'b1001, 32'hA, 1));
        tbl.push_back(mk(0, 1, 0, 4'b0100, 32'hC, 1, 0, 4'b1001, 32'hA, 2));
        tbl.push_back(mk(0, 1, 1, 4'b0100, 32'hC, 1, 0, 4'b1001, 32'hA, 3));
        tbl.push_back(mk(0, 1, 1, 4'b0100, 32'hC, 1, 1, 4'b0010, 32'hB, 3));
        tbl.push_back(mk(0, 0, 1, 4'b0000, 32'h0, 1, 1, 4'b0100, 32'hC, 3));
        tbl.push_back(mk(0, 0, 1, 4'b0000, 32'h0, 0, 1, 4'b0100, 32'hC, 3));
        // Flush from TWO with a valid input: everything discarded.
        tbl.push_back(mk(0, 1, 0, 4'b1111, 32'hD, 0, 1, 4'b0100, 32'hC, 3));
        tbl.push_back(mk(0, 1, 0, 4'b1001, 32'hE, 1, 1, 4'b1111, 32'hD, 3));
        tbl.push_back(mk(1, 1, 0, 4'b1111, 32'hF0, 1, 0, 4'b1111, 32'hD, 4));
        tbl.push_back(mk(0, 0, 0, 4'b0000, 32'h0, 0, 1, 4'b0110, 32'hD, 5));
        tbl.push_back(mk(0, 0, 1, 4'b0000, 32'h0, 0, 1, 4'b0110, 32'hD, 5));
        tbl.push_back(mk(1, 1, 1, 4'b1111, 32'h77, 0, 1, 4'b0110, 32'hD, 5));
        tbl.push_back(mk(0, 0, 1, 4'b0000, 32'h0, 0, 1, 4'b0110, 32'hD, 5));

        foreach (tbl[i]) begin
            applyStimulus(tbl[i]);
            checkOutput($sformatf("vec%0d_out_valid", i), 64'(out_valid), 64'(tbl[i].exp_ov));
            checkOutput($sformatf("vec%0d_in_ready", i),  64'(in_ready),  64'(tbl[i].exp_ir));
            checkOutput($sformatf("vec%0d_ctrl", i),      64'(ctrl_out),  64'(tbl[i].exp_ctrl));
            checkOutput($sformatf("vec%0d_alu", i),       64'(alu_out),   64'(tbl[i].exp_alu));
            checkOutput($sformatf("vec%0d_cnt", i),       64'(stall_cnt), 64'(tbl[i].exp_cnt));
            tick();
        end

        // Saturation on the 4-bit counter instance, then flush must not clear it.
        s_rst = 1'b0; s_in_valid = 1'b1;
        tick();
        s_in_valid = 1'b0;
        for (int k = 1; k <= 20; k++) begin
            tick();
            checkOutput($sformatf("sat_cnt_%0d", k), 64'(s_stall_cnt), 64'((k > 15) ? 15 : k));
        end
        s_flush = 1'b1;
        tick();
        s_flush = 1'b0;
        checkOutput("sat_after_flush_cnt",   64'(s_stall_cnt), 64'd15);
        checkOutput("sat_after_flush_valid", 64'(s_out_valid), 64'd0);
        checkOutput("sat_after_flush_ctrl",  64'(s_ctrl_out),  64'b0110);
        tick();
        checkOutput("sat_hold_cnt", 64'(s_stall_cnt), 64'd15);

        // Randomized traffic against a queue model of capacity two.
        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        tick();
        q.delete();
        last      = '{ctrl: '0, alu: '0, wdata: '0, rd: '0};
        model_cnt = 0;
        for (int cyc = 0; cyc < 600; cyc++) begin
            rst       = ($urandom_range(0, 59) == 0);
            flush     = ($urandom_range(0, 15) == 0);
            in_valid  = ($urandom_range(0, 9) < 6);
            out_ready = ($urandom_range(0, 9) < 6);
            ctrl_in   = 4'($urandom);
            alu_in    = $urandom;
            wdata_in  = $urandom;
            rd_in     = 5'($urandom);

            m_ov  = (q.size() > 0);
            m_ir  = (q.size() < 2);
            exp_c = m_ov ? last.ctrl : (last.ctrl & 4'b0110);
            checkOutput("rnd_out_valid", 64'(out_valid), 64'(m_ov));
            checkOutput("rnd_in_ready",  64'(in_ready),  64'(m_ir));
            checkOutput("rnd_ctrl",      64'(ctrl_out),  64'(exp_c));
            checkOutput("rnd_alu",       64'(alu_out),   64'(last.alu));
            checkOutput("rnd_wdata",     64'(wdata_out), 64'(last.wdata));
            checkOutput("rnd_rd",        64'(rd_out),    64'(last.rd));
            checkOutput("rnd_cnt",       64'(stall_cnt), 64'(model_cnt));

            in_fire  = in_valid && m_ir;
            out_fire = m_ov && out_ready;
            tick();
            if (rst) begin
                q.delete();
                last      = '{ctrl: '0, alu: '0, wdata: '0, rd: '0};
                model_cnt = 0;
            end else begin
                if (m_ov && !out_ready && model_cnt < 65535)
                    model_cnt++;
                if (flush) begin
                    q.delete();
                end else begin
                    if (out_fire)
                        void'(q.pop_front());
                    if (in_fire) begin
                        e = '{ctrl: ctrl_in, alu: alu_in, wdata: wdata_in, rd: rd_in};
                        q.push_back(e);
                    end
                end
                if (q.size() > 0)
                    last = q[0];
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
